// File: rtl/detect_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | detect_pkg : state type and shared "two ones" Moore functions   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package detect_pkg;

   typedef enum logic [1:0] {
      ST_A = 2'b00,
      ST_B = 2'b01,
      ST_C = 2'b10
   } state_t;

   function automatic state_t detect_next(input state_t st, input logic w);
      state_t nxt;
      case (st)
         ST_A:    nxt = w ? ST_B : ST_A;
         ST_B:    nxt = w ? ST_C : ST_A;
         ST_C:    nxt = w ? ST_C : ST_A;
         default: nxt = ST_A;   // unused code 11 recovers to A
      endcase
      return nxt;
   endfunction

   function automatic logic detect_out(input state_t st);
      return (st == ST_C);
   endfunction

endpackage
`default_nettype wire

// File: rtl/detect_rr_scheduler_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | detect_rr_scheduler_if : request/grant and status bundle        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface detect_rr_scheduler_if #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8
);
   logic                     en;
   logic                     clr;
   logic [NCH-1:0]           req;
   logic [NCH-1:0]           bit_in;
   logic [NCH-1:0]           grant;
   logic [NCH-1:0]           z;
   logic [NCH*CNT_W-1:0]     hit_cnt;
   logic                     match_valid;
   logic [$clog2(NCH)-1:0]   match_ch;

   modport master (
      output en, clr, req, bit_in,
      input  grant, z, hit_cnt, match_valid, match_ch
   );

   modport slave (
      input  en, clr, req, bit_in,
      output grant, z, hit_cnt, match_valid, match_ch
   );
endinterface
`default_nettype wire

// File: rtl/detect_rr_scheduler_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_arbiter : rotating-pointer round-robin, one-hot grant        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module rr_arbiter #(
   parameter int N = 4
) (
   input  wire logic                   clk,
   input  wire logic                   resetn,
   input  wire logic [N-1:0]           req_i,
   input  wire logic                   en_i,
   output logic      [N-1:0]           grant_o,
   output logic      [$clog2(N)-1:0]   idx_o
);
   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic [IW-1:0] cand;
   logic          found;

   // Search upward from ptr, wrapping modulo N; first requester wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      ptr_d   = ptr_q;
      if (en_i) begin
         for (int off = 0; off < N; off++) begin
            cand = IW'((int'(ptr_q) + off) % N);
            if (!found && req_i[cand]) begin
               found          = 1'b1;
               grant_o[cand]  = 1'b1;
               idx_o          = cand;
            end
         end
      end
      if (found)
         ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         ptr_q <= '0;
      else
         ptr_q <= ptr_d;
   end

endmodule
`default_nettype wire

// File: rtl/detect_rr_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | detect_rr_scheduler : one shared detector time-sliced over NCH  |
// | serial channels with per-channel state and hit counters. Rev 1.0|
// +-----------------------------------------------------------------+
module detect_rr_scheduler
   import detect_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int CNT_W = 8
) (
   input wire logic             clk,
   input wire logic             resetn,
   detect_rr_scheduler_if.slave bus
);
   localparam int               IW      = $clog2(NCH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           st_q  [NCH];
   state_t           st_d  [NCH];
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];
   logic [NCH-1:0]   z_q,  z_d;
   logic             mv_q, mv_d;
   logic [IW-1:0]    mch_q, mch_d;

   logic             arb_en;
   logic [NCH-1:0]   grant;
   logic [IW-1:0]    gidx;
   logic             any_grant;
   state_t           st_nxt;

   // Clear and reset both suppress the grant so no pending bit is consumed.
   assign arb_en = bus.en & ~bus.clr & resetn;

   rr_arbiter #(
      .N (NCH)
   ) u_arb (
      .clk     (clk),
      .resetn  (resetn),
      .req_i   (bus.req),
      .en_i    (arb_en),
      .grant_o (grant),
      .idx_o   (gidx)
   );

   assign any_grant = |grant;
   assign st_nxt    = detect_next(st_q[gidx], bus.bit_in[gidx]);

   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      z_d   = z_q;
      mv_d  = 1'b0;
      mch_d = mch_q;
      if (bus.clr) begin
         for (int i = 0; i < NCH; i++) begin
            st_d[i]  = ST_A;
            cnt_d[i] = '0;
         end
         z_d = '0;
      end else if (any_grant) begin
         st_d[gidx] = st_nxt;
         z_d[gidx]  = detect_out(st_nxt);
         if (st_nxt == ST_C) begin
            if (cnt_q[gidx] != CNT_MAX)
               cnt_d[gidx] = cnt_q[gidx] + 1'b1;
            mv_d  = 1'b1;
            mch_d = gidx;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NCH; i++) begin
            st_q[i]  <= ST_A;
            cnt_q[i] <= '0;
         end
         z_q   <= '0;
         mv_q  <= 1'b0;
         mch_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         z_q   <= z_d;
         mv_q  <= mv_d;
         mch_q <= mch_d;
      end
   end

   assign bus.grant       = grant;
   assign bus.z           = z_q;
   assign bus.match_valid = mv_q;
   assign bus.match_ch    = mch_q;

   for (genvar i = 0; i < NCH; i++) begin : g_cnt_out
      assign bus.hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
   end

endmodule
`default_nettype wire

// File: tb/tb_detect_rr_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_detect_rr_scheduler : directed steps with a reference model  |
// | and a queue of expected match channels. Rev 1.0                 |
// +-----------------------------------------------------------------+
module tb_detect_rr_scheduler;
   localparam int NCH   = 4;
   localparam int CNT_W = 2;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   detect_rr_scheduler_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

   detect_rr_scheduler #(.NCH(NCH), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0]       m_st  [NCH];
   logic [CNT_W-1:0] m_cnt [NCH];
   int               exp_q [$];

   function automatic logic [1:0] ref_next(input logic [1:0] s, input logic w);
      case (s)
         2'b00:   return w ? 2'b01 : 2'b00;
         2'b01:   return w ? 2'b10 : 2'b00;
         2'b10:   return w ? 2'b10 : 2'b00;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [NCH-1:0] m_z();
      logic [NCH-1:0] r;
      for (int i = 0; i < NCH; i++) r[i] = (m_st[i] == 2'b10);
      return r;
   endfunction

   function automatic logic [NCH*CNT_W-1:0] m_hc();
      logic [NCH*CNT_W-1:0] r;
      for (int i = 0; i < NCH; i++) r[i*CNT_W +: CNT_W] = m_cnt[i];
      return r;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NCH; i++) begin
         m_st[i]  = 2'b00;
         m_cnt[i] = '0;
      end
      exp_q.delete();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Entered just after a falling edge; returns just after the next one.
   task automatic step(input string tag, input logic [NCH-1:0] r, input logic [NCH-1:0] b,
                       input logic e, input logic c, input logic [NCH-1:0] g);
      logic       exp_mv;
      logic [1:0] nx;
      int         k;
      bus.req    = r;
      bus.bit_in = b;
      bus.en     = e;
      bus.clr    = c;
      #1;
      chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
      exp_mv = 1'b0;
      if (c) begin
         for (int i = 0; i < NCH; i++) begin
            m_st[i]  = 2'b00;
            m_cnt[i] = '0;
         end
      end else if (g != '0) begin
         k = 0;
         for (int i = 0; i < NCH; i++) if (g[i]) k = i;
         nx = ref_next(m_st[k], b[k]);
         m_st[k] = nx;
         if (nx == 2'b10) begin
            if (m_cnt[k] != '1) m_cnt[k] = m_cnt[k] + 1'b1;
            exp_q.push_back(k);
            exp_mv = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".z"},       32'(bus.z),           32'(m_z()));
      chk({tag, ".hit_cnt"}, 32'(bus.hit_cnt),     32'(m_hc()));
      chk({tag, ".mvalid"},  32'(bus.match_valid), 32'(exp_mv));
      if (exp_mv && exp_q.size() > 0)
         chk({tag, ".mch"}, 32'(bus.match_ch), 32'(exp_q.pop_front()));
   endtask

   initial begin
      resetn     = 1'b0;
      bus.en     = 1'b1;
      bus.clr    = 1'b0;
      bus.req    = '1;
      bus.bit_in = '0;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst.grant",  32'(bus.grant),       32'h0);
      chk("rst.z",      32'(bus.z),           32'h0);
      chk("rst.hit",    32'(bus.hit_cnt),     32'h0);
      chk("rst.mvalid", 32'(bus.match_valid), 32'h0);
      chk("rst.mch",    32'(bus.match_ch),    32'h0);
      resetn  = 1'b1;
      bus.req = '0;

      // Channel 0 alone: bits 1,1,1,0
      step("t1.b0", 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001);
      step("t1.b1", 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001);
      step("t1.b2", 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001);
      step("t1.b3", 4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001);
      chk("t1.cnt0", 32'(bus.hit_cnt[1:0]), 32'd2);

      // Bring pointer back to 0, then full load
      step("t2.pre", 4'b1000, 4'b0000, 1'b1, 1'b0, 4'b1000);
      for (int i = 0; i < 8; i++)
         step("t2.load", 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001 << (i % 4));

      // Pointer to 2, then clear with a pending request
      step("t5.pre", 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010);
      step("t5.clr", 4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0000);

      // Interleaved ch1 (1,1) and ch2 (1,0); pointer still 2 after clear
      step("t3.s0", 4'b0110, 4'b0110, 1'b1, 1'b0, 4'b0100);
      step("t3.s1", 4'b0110, 4'b0010, 1'b1, 1'b0, 4'b0010);
      step("t3.s2", 4'b0110, 4'b0010, 1'b1, 1'b0, 4'b0100);
      step("t3.s3", 4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0010);
      chk("t3.z", 32'(bus.z), 32'b0010);

      // Enable low: nothing granted or changed
      step("en0", 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000);

      // Saturation on channel 3
      for (int i = 0; i < 6; i++)
         step("t4.sat", 4'b1000, 4'b1000, 1'b1, 1'b0, 4'b1000);
      chk("t4.cnt3", 32'(bus.hit_cnt[7:6]), 32'd3);

      // Drive every channel into C, leave pointer at 1
      for (int i = 0; i < 8; i++)
         step("t6.fill", 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001 << (i % 4));
      chk("t6.zall", 32'(bus.z), 32'b1111);
      step("t6.ptr1", 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001);

      // Asynchronous reset mid-cycle
      bus.req = 4'b1111;
      bus.en  = 1'b1;
      #2 resetn = 1'b0;
      #1;
      chk("t6.rst.grant",  32'(bus.grant),       32'h0);
      chk("t6.rst.z",      32'(bus.z),           32'h0);
      chk("t6.rst.hit",    32'(bus.hit_cnt),     32'h0);
      chk("t6.rst.mvalid", 32'(bus.match_valid), 32'h0);
      m_reset();
      @(negedge clk);
      resetn = 1'b1;
      step("t6.post", 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0001);

      bus.req = '0;
      chk("sb.empty", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
